ialu_stage: RTL
===============

// Module: ialu_stage
// PURPOSE
//  Execute/writeback stage feeding the integer register file (64 x 32b, 6b addresses).
//  Accepts one ALU op per cycle over valid/ready, drives the file's two read addresses,
//  computes the result and drives the file's write port (rw/dw/we).
//  Forwards in-flight results so back-to-back dependent ops read correct values.
// PARAMETERS
//  XLEN   32  datapath width; equals register-file word width
//  AW     6   register address width (64 registers)
//  MULCYC 32  iterations of the iterative multiplier (only with IALU_MUL_EN)
// PORTS
//  clk         in   1     single clock; all state on posedge
//  reset       in   1     asynchronous, active-high reset
//  in_valid    in   1     op request valid
//  in_ready    out  1     stage can accept; transfer when in_valid & in_ready
//  in_op       in   4     opcode (see ialu_defs.vh)
//  in_rs0      in   AW    source register A
//  in_rs1      in   AW    source register B
//  in_rd       in   AW    destination register
//  in_imm      in   XLEN  immediate for LIMM
//  r0, r1      out  AW    register-file read addresses (comb. = in_rs0/in_rs1)
//  d0, d1      in   XLEN  register-file read data (combinational read)
//  rw          out  AW    register-file write address
//  dw          out  XLEN  register-file write data
//  we          out  1     register-file write enable
//  busy        out  1     E stage occupied (incl. multiply in progress)
//  err_illegal out  1     one-cycle pulse: undefined opcode executed, no write
// BEHAVIOUR
//  Reset (async, reset=1): in_ready=0 while asserted, 1 on first edge after release;
//   we=0, rw=0, dw=0, busy=0, err_illegal=0, E stage invalid, mul FSM IDLE.
//   Reset mid-multiply aborts it; no write issued for the aborted op.
//  Pipeline: accept at edge k -> E stage valid in cycle k..k+1 -> W regs (rw/dw/we)
//   loaded at edge k+1 -> register file written at edge k+2. Throughput 1 op/cycle.
//  Operand select at accept (per source, priority order):
//   1) E valid, E writes, E.rd == rs  -> E combinational result
//   2) we==1 and rw == rs             -> dw
//   3) otherwise                      -> d0 / d1
//  Ops: ADD,SUB (mod 2^XLEN, no flags); AND,OR,XOR; SHL,SHR,SAR (shift = B[4:0]);
//   LIMM (dw=in_imm, ignores sources); CMPEQ,CMPLT (signed) -> 32'd1/32'd0;
//   NOP (no write); MUL (see CONFIGURATION). Other codes -> illegal.
//  Illegal op: err_illegal=1 for the cycle W would have been written; we=0.
//  we is high for exactly one cycle per writing op; rw/dw hold last value when we=0.
//  in_valid without in_ready: request must be held stable by sender; no side effects.
//  Simultaneous: W writing reg X while E forwards X -> forward takes priority (newer).
//  Writes to any register incl. 0 are legal (no hardwired zero).
// CONFIGURATION
//  IALU_MUL_EN defined: MUL = low XLEN bits of A*B, iterative shift-add FSM
//   IDLE -> RUN (MULCYC cycles, in_ready=0, busy=1) -> DONE (load W, we=1) -> IDLE.
//   Accept of MUL at edge k -> we asserted after edge k+MULCYC+1. Dependent op
//   accepted after DONE receives product via W forward.
//  IALU_MUL_EN undefined: MUL is an illegal opcode (err_illegal pulse, no write),
//   multiplier not instantiated.
// STRUCTURE
//  ialu_defs.vh: opcode localparams (OP_NOP..OP_MUL), XLEN/AW defaults, mul FSM states;
//   shared with the decoder that drives in_*.
//  Sub-module ialu_mul (IALU_MUL_EN only): start/done iterative multiplier.
//  ALU function is a combinational block inside ialu_stage.
// TESTING
//  Reset then LIMM r3=0x12345678 -> we=1, rw=3, dw=0x12345678 two edges after accept.
//  LIMM r1=5; ADD r2=r1+r1 back-to-back -> dw=10 via E forward, no stall.
//  LIMM r1=5; NOP; ADD r2=r1+r1 -> dw=10 via W forward.
//  SUB 0-1 -> 0xFFFFFFFF; SAR 0x80000000 by 4 -> 0xF8000000; CMPLT -1<1 -> 1.
//  MUL 7*6 with IALU_MUL_EN -> in_ready low 32 cycles, dw=42; without -> err_illegal.
//  Assert reset during MUL RUN -> no we, outputs at reset values, next op normal.

Source files
------------

// File: rtl/ialu_stage_pkg.sv
// Shared opcodes, default widths and multiplier FSM states for ialu_stage and its decoder.
// IALU_MUL_EN makes OP_MUL a legal, writing opcode; otherwise it decodes as illegal.
package ialu_stage_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int AW_DEF     = 6;
   localparam int MULCYC_DEF = 32;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_SHL   = 4'd6,
      OP_SHR   = 4'd7,
      OP_SAR   = 4'd8,
      OP_LIMM  = 4'd9,
      OP_CMPEQ = 4'd10,
      OP_CMPLT = 4'd11,
      OP_MUL   = 4'd12
   } op_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      ok = (op <= OP_CMPLT);
`ifdef IALU_MUL_EN
      if (op == OP_MUL) ok = 1'b1;
`endif
      return ok;
   endfunction

   function automatic logic op_writes(input logic [3:0] op);
      return op_legal(op) && (op != OP_NOP);
   endfunction

endpackage

// File: rtl/ialu_stage_mul.sv
// Iterative shift-add multiplier (low XLEN bits of a*b), start/done handshake.
// Only compiled when IALU_MUL_EN is defined.
`ifdef IALU_MUL_EN
module ialu_mul
   import ialu_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int MULCYC = MULCYC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            run,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CW = $clog2(MULCYC + 1);

   mul_state_t      state_reg;
   logic [XLEN-1:0] a_reg;
   logic [XLEN-1:0] b_reg;
   logic [XLEN-1:0] acc_reg;
   logic [CW-1:0]   cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= MUL_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            MUL_IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               if (b_reg[0]) acc_reg <= acc_reg + a_reg;
               a_reg   <= a_reg << 1;
               b_reg   <= b_reg >> 1;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(MULCYC - 1)) state_reg <= MUL_DONE;
            end
            MUL_DONE: begin
               // The stage may accept a new MUL in the same cycle the product retires.
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= MUL_RUN;
               end else begin
                  state_reg <= MUL_IDLE;
               end
            end
            default: state_reg <= MUL_IDLE;
         endcase
      end
   end

   assign run     = (state_reg == MUL_RUN);
   assign done    = (state_reg == MUL_DONE);
   assign product = acc_reg;

endmodule
`endif

// File: rtl/ialu_stage.sv
// Execute/writeback stage for a 64x32 register file with E- and W-stage operand forwarding.
// IALU_MUL_EN adds an iterative multiplier for OP_MUL; without it OP_MUL is illegal.
module ialu_stage
   import ialu_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
`ifdef IALU_MUL_EN
   ,
   parameter int MULCYC = MULCYC_DEF
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [AW-1:0]   in_rs0,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_imm,
   output logic [AW-1:0]   r0,
   output logic [AW-1:0]   r1,
   input  logic [XLEN-1:0] d0,
   input  logic [XLEN-1:0] d1,
   output logic [AW-1:0]   rw,
   output logic [XLEN-1:0] dw,
   output logic            we,
   output logic            busy,
   output logic            err_illegal
);

   logic            rdy_reg;
   logic            e_valid_reg;
   logic [3:0]      e_op_reg;
   logic [AW-1:0]   e_rd_reg;
   logic [XLEN-1:0] e_a_reg;
   logic [XLEN-1:0] e_b_reg;
   logic [XLEN-1:0] e_imm_reg;
   logic [AW-1:0]   rw_reg;
   logic [XLEN-1:0] dw_reg;
   logic            we_reg;
   logic            err_reg;

   logic [XLEN-1:0] e_result;
   logic            e_writes;
   logic            e_legal;
   logic            e_fin;
   logic            accept;

   logic [1:0][AW-1:0]   rs;
   logic [1:0][XLEN-1:0] rf_data;
   logic [1:0][XLEN-1:0] opnd;

   assign r0      = in_rs0;
   assign r1      = in_rs1;
   assign rs      = {in_rs1, in_rs0};
   assign rf_data = {d1, d0};

   assign e_writes = op_writes(e_op_reg);
   assign e_legal  = op_legal(e_op_reg);

   // E result is the newest value of its rd, so it outranks the W register.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign opnd[gi] = (e_valid_reg && e_writes && (e_rd_reg == rs[gi])) ? e_result :
                           (we_reg && (rw_reg == rs[gi]))                     ? dw_reg   :
                                                                                rf_data[gi];
      end
   endgenerate

`ifdef IALU_MUL_EN
   logic            mul_run;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;

   ialu_mul #(
      .XLEN   (XLEN),
      .MULCYC (MULCYC)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && (in_op == OP_MUL)),
      .a       (opnd[0]),
      .b       (opnd[1]),
      .run     (mul_run),
      .done    (mul_done),
      .product (mul_product)
   );

   assign in_ready = rdy_reg && !mul_run;
   assign e_fin    = e_valid_reg && ((e_op_reg != OP_MUL) || mul_done);
`else
   assign in_ready = rdy_reg;
   assign e_fin    = e_valid_reg;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      e_result = '0;
      case (e_op_reg)
         OP_ADD:   e_result = e_a_reg + e_b_reg;
         OP_SUB:   e_result = e_a_reg - e_b_reg;
         OP_AND:   e_result = e_a_reg & e_b_reg;
         OP_OR:    e_result = e_a_reg | e_b_reg;
         OP_XOR:   e_result = e_a_reg ^ e_b_reg;
         OP_SHL:   e_result = e_a_reg << e_b_reg[4:0];
         OP_SHR:   e_result = e_a_reg >> e_b_reg[4:0];
         OP_SAR:   e_result = $signed(e_a_reg) >>> e_b_reg[4:0];
         OP_LIMM:  e_result = e_imm_reg;
         OP_CMPEQ: e_result = XLEN'(e_a_reg == e_b_reg);
         OP_CMPLT: e_result = XLEN'($signed(e_a_reg) < $signed(e_b_reg));
`ifdef IALU_MUL_EN
         OP_MUL:   e_result = mul_product;
`endif
         default:  e_result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_reg     <= 1'b0;
         e_valid_reg <= 1'b0;
         e_op_reg    <= '0;
         e_rd_reg    <= '0;
         e_a_reg     <= '0;
         e_b_reg     <= '0;
         e_imm_reg   <= '0;
         rw_reg      <= '0;
         dw_reg      <= '0;
         we_reg      <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         rdy_reg <= 1'b1;
         we_reg  <= 1'b0;
         err_reg <= 1'b0;
         if (e_fin) begin
            if (e_writes) begin
               we_reg <= 1'b1;
               rw_reg <= e_rd_reg;
               dw_reg <= e_result;
            end
            err_reg <= !e_legal;
         end
         if (accept) begin
            e_valid_reg <= 1'b1;
            e_op_reg    <= in_op;
            e_rd_reg    <= in_rd;
            e_a_reg     <= opnd[0];
            e_b_reg     <= opnd[1];
            e_imm_reg   <= in_imm;
         end else if (e_fin) begin
            e_valid_reg <= 1'b0;
         end
      end
   end

   assign rw          = rw_reg;
   assign dw          = dw_reg;
   assign we          = we_reg;
   assign err_illegal = err_reg;
   assign busy        = e_valid_reg;

endmodule
